mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin scheduler for the shared 4:1 x 2-bit selector mux (select S[1:0], active-low EN).
//  Four requesters raise req; one grantee at a time holds the mux for a bounded burst.
//  Drives mux select/enable directly, plus one-hot grant back to requesters.
// PARAMETERS
//  BURST_LEN  4  max cycles a grantee holds the mux per grant (1..255)
//  CNT_W      8  burst counter width; must satisfy BURST_LEN <= 2**CNT_W-1
// PORTS
//  clk     in   1  single clock, rising edge
//  rst     in   1  synchronous reset, active-high
//  req     in   4  request per source; req[i] = source i wants mux input i
//  grant   out  4  one-hot grant, registered; 4'b0000 when no owner
//  sel     out  2  mux select (S); index of current grantee, holds last value when idle
//  en_n    out  1  mux enable, active-low; 0 only while a grant is active
//  busy    out  1  1 while in GRANT (or GAP when enabled)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, grant=0, sel=2'b00, en_n=1, busy=0, cnt=0, ptr=3 (source 0 wins first).
//  States: IDLE, GRANT, GAP (GAP only with ARB_GAP_EN).
//  Arbitration: search order ptr+1, ptr+2, ptr+3, ptr (mod 4); first set req bit wins.
//   - ptr <= winner index at the moment of grant; the winner therefore has lowest priority next time.
//  IDLE: req==0 -> stay. req!=0 sampled at edge N -> GRANT from edge N; grant/sel/en_n visible cycle after N.
//   - latency req->grant = 1 cycle; all outputs are registers, no comb path req->grant.
//  GRANT: cnt increments each cycle starting at 0 on grant cycle.
//   - Release when req[sel]==0 (owner dropped) OR cnt==BURST_LEN-1 (burst exhausted).
//   - Owner drop is sampled: grant is held through the cycle in which req[sel] is seen low, released next edge.
//   - BURST_LEN=1: every grant lasts exactly 1 cycle.
//  Release without ARB_GAP_EN: arbitrate in release cycle using req and updated ptr;
//   - another requester pending -> new grant next cycle, back-to-back, en_n stays 0, sel changes.
//   - only the releasing owner still requesting -> it is re-granted (fresh burst, cnt=0).
//   - no requests -> IDLE: grant=0, en_n=1, sel holds.
//  Simultaneous requests: resolved purely by RR order above; never two grant bits set.
//  grant, sel and en_n always consistent: en_n==0 iff grant!=0 and grant==(1<<sel).
//  req change of non-owners during a burst: ignored until release.
//  rst mid-burst: outputs take reset values at that edge; ptr returns to 3.
//  cnt saturates protection: never exceeds BURST_LEN-1.
// CONFIGURATION
//  ARB_GAP_EN defined: every release goes to GAP for exactly 1 cycle (grant=0, en_n=1, busy=1),
//   then arbitrates as from IDLE; avoids select glitch between owners. Grant-to-grant min spacing = 1 idle cycle.
//  ARB_GAP_EN undefined: GAP state absent; back-to-back handoff as described above.
// TESTING
//  1 Reset: rst=1 two cycles with req=4'b1111 -> grant=0, en_n=1, sel=0, busy=0 throughout.
//  2 Single source: req=4'b0100 held, BURST_LEN=4 -> grant=0100, sel=2, en_n=0 from cycle 1;
//    re-granted every 4 cycles (no gap w/o macro; 1 idle cycle every 4 with ARB_GAP_EN).
//  3 Fairness: req=4'b1111 held -> grants 0001,0010,0100,1000,0001... each 4 cycles long, sel 0,1,2,3,0.
//  4 Early drop: source 1 granted, req[1] falls at burst cycle 1 -> grant released after that cycle
//    (2 cycles held), next pending source (e.g. 3 with req=4'b1000) granted next cycle.
//  5 Reset mid-burst: rst=1 at burst cycle 2 of source 2 -> next cycle grant=0, en_n=1; after rst low with
//    req=4'b0101, source 0 wins first.
//  6 Mux integration: drive mux A..D=2'b00,01,10,11 with sel/en_n, req=4'b1010 -> Y alternates 01 (4 cyc), 11 (4 cyc); Y=00 when idle.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin scheduler for a shared 4:1 mux: registered one-hot grant, mux select and active-low enable.
// Optional macro ARB_GAP_EN inserts a one-cycle GAP state between consecutive grants.
module mux4_rr_arbiter #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       en_n,
    output logic       busy
);

`ifdef ARB_GAP_EN
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic             en_n_q, en_n_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic       do_arb;

    // Search ptr+1, ptr+2, ptr+3, ptr so the last winner ranks lowest.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            if (!pick_valid && req[ptr_q + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        en_n_d  = en_n_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        do_arb  = 1'b0;

        case (state_q)
            IDLE: do_arb = 1'b1;
            GRANT: begin
                if (!req[sel_q] || (cnt_q == CNT_LAST)) begin
`ifdef ARB_GAP_EN
                    state_d = GAP;
                    grant_d = '0;
                    en_n_d  = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
`else
                    do_arb  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef ARB_GAP_EN
            GAP: do_arb = 1'b1;
`endif
            default: state_d = IDLE;
        endcase

        if (do_arb) begin
            if (pick_valid) begin
                state_d = GRANT;
                grant_d = 4'b0001 << pick_idx;
                sel_d   = pick_idx;
                en_n_d  = 1'b0;
                busy_d  = 1'b1;
                cnt_d   = '0;
                ptr_d   = pick_idx;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                en_n_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            en_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            en_n_q  <= en_n_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign en_n  = en_n_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios then random requests, checked against an owner/hold-count model.
module tb_mux4_rr_arbiter;

    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       en_n;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the mux, for how many cycles, and the RR pointer.
    int owner    = -1;
    int held     = 0;
    int ptr      = 3;
    int last_sel = 0;
    bit in_gap   = 1'b0;

    logic [1:0] mux_data [4];
    logic [1:0] mux_y;

    mux4_rr_arbiter #(.BURST_LEN(BURST), .CNT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant),
        .sel   (sel),
        .en_n  (en_n),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        mux_data[0] = 2'b00;
        mux_data[1] = 2'b01;
        mux_data[2] = 2'b10;
        mux_data[3] = 2'b11;
    end
    assign mux_y = en_n ? 2'b00 : mux_data[sel];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_pick(input logic [3:0] r);
        owner = -1;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (ptr + k) % 4;
            if (owner < 0 && r[idx]) begin
                owner    = idx;
                ptr      = idx;
                held     = 0;
                last_sel = idx;
            end
        end
    endtask

    task automatic model_edge(input logic r_rst, input logic [3:0] r);
        if (r_rst) begin
            owner = -1; held = 0; ptr = 3; last_sel = 0; in_gap = 1'b0;
        end else if (owner >= 0) begin
            held++;
            if (!r[owner] || held >= BURST) begin
`ifdef ARB_GAP_EN
                owner  = -1;
                in_gap = 1'b1;
`else
                model_pick(r);
`endif
            end
        end else begin
            in_gap = 1'b0;
            model_pick(r);
        end
    endtask

    task automatic step();
        logic [3:0] exp_grant;
        @(posedge clk);
        model_edge(rst, req);
        #1;
        exp_grant = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
        check("grant", 8'(grant), 8'(exp_grant));
        check("sel",   8'(sel),   8'(last_sel));
        check("en_n",  8'(en_n),  8'(owner < 0));
        check("busy",  8'(busy),  8'((owner >= 0) || in_gap));
        check("mux_y", 8'(mux_y), 8'((owner >= 0) ? owner : 0));
    endtask

    initial begin
        // Reset held with all requests active
        rst = 1'b1; req = 4'b1111;
        step(); step();
        rst = 1'b0;

        // Single source, repeated bursts
        req = 4'b0100;
        repeat (12) step();

        // All sources: rotating fairness
        req = 4'b1111;
        repeat (20) step();

        // Early drop of source 1, source 3 pending
        rst = 1'b1; req = 4'b0000; step(); rst = 1'b0;
        req = 4'b0010; step();
        check("drop_first", 8'(grant), 8'h02);
        step();
        req = 4'b1000; step();
        check("drop_next", 8'(grant), 8'h00 | ((owner >= 0) ? (8'h01 << owner) : 8'h00));
        repeat (4) step();

        // Reset mid-burst of source 2
        rst = 1'b1; req = 4'b0000; step(); rst = 1'b0;
        req = 4'b0100; step(); step(); step();
        rst = 1'b1; step();
        check("rst_mid_grant", 8'(grant), 8'h00);
        check("rst_mid_en_n", 8'(en_n), 8'h01);
        rst = 1'b0; req = 4'b0101; step();
        check("rst_after_src0", 8'(grant), 8'h01);
        repeat (6) step();

        // Mux integration, sources 1 and 3 alternating, then idle
        req = 4'b1010;
        repeat (16) step();
        req = 4'b0000;
        repeat (4) step();
        check("idle_y", 8'(mux_y), 8'h00);

        // Random requests with occasional reset
        for (int i = 0; i < 500; i++) begin
            req = 4'($urandom);
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
